// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: job sequencer for an external 16x16->32 MAC (clear, stream N pairs, drain, return).
// Optional stall timeout is enabled by defining MACSEQ_TIMEOUT_EN.
module mac_seq_ctrl #(
    parameter int DATA_W  = 16,
    parameter int ACC_W   = 32,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_y,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic              res_err,
    output logic              mac_rst,
    output logic [DATA_W-1:0] mac_x,
    output logic [DATA_W-1:0] mac_y,
    input  logic [ACC_W-1:0]  mac_acc
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             r_state;
    logic               r_busy;
    logic               r_in_ready;
    logic               r_res_valid;
    logic               r_mac_clr;
    logic [ACC_W-1:0]   r_res_data;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_count;
    logic               w_beat;
    logic               w_last;

`ifdef MACSEQ_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);
    logic [STALL_W-1:0] r_stall;
    logic               r_timed_out;
    logic               r_res_err;
    logic               w_stall_hit;
`else
    // Keeps the parameter referenced in builds without the stall timer.
    if (TIMEOUT < 1) begin : g_timeout_unused
    end
`endif

    // Beat qualification and end-of-job / stall-limit detection.
    always_comb begin
        w_beat = in_valid & r_in_ready;
        w_last = (r_count == (r_len - LEN_W'(1)));
`ifdef MACSEQ_TIMEOUT_EN
        w_stall_hit = (r_stall == STALL_W'(TIMEOUT - 1));
`endif
    end

    assign busy      = r_busy;
    assign in_ready  = r_in_ready;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    // MAC must clear together with us while rst is held, not one cycle later.
    assign mac_rst   = rst | r_mac_clr;
    assign mac_x     = w_beat ? in_x : {DATA_W{1'b0}};
    assign mac_y     = w_beat ? in_y : {DATA_W{1'b0}};
`ifdef MACSEQ_TIMEOUT_EN
    assign res_err   = r_res_err;
`else
    assign res_err   = 1'b0;
`endif

    // Sequencer FSM with registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_res_valid <= 1'b0;
            r_mac_clr   <= 1'b0;
            r_res_data  <= {ACC_W{1'b0}};
            r_len       <= {LEN_W{1'b0}};
            r_count     <= {LEN_W{1'b0}};
`ifdef MACSEQ_TIMEOUT_EN
            r_stall     <= {STALL_W{1'b0}};
            r_timed_out <= 1'b0;
            r_res_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_CLEAR;
                        r_len     <= len;
                        r_count   <= {LEN_W{1'b0}};
                        r_busy    <= 1'b1;
                        r_mac_clr <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CLEAR: begin
                    r_mac_clr <= 1'b0;
`ifdef MACSEQ_TIMEOUT_EN
                    r_stall     <= {STALL_W{1'b0}};
                    r_timed_out <= 1'b0;
`endif
                    if (r_len == {LEN_W{1'b0}}) begin
                        r_state     <= S_DONE;
                        r_res_data  <= {ACC_W{1'b0}};
                        r_res_valid <= 1'b1;
                    end else begin
                        r_state    <= S_RUN;
                        r_in_ready <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_beat) begin
                        r_count <= r_count + LEN_W'(1);
`ifdef MACSEQ_TIMEOUT_EN
                        r_stall <= {STALL_W{1'b0}};
`endif
                        if (w_last) begin
                            r_state    <= S_DRAIN;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
`ifdef MACSEQ_TIMEOUT_EN
                    else if (w_stall_hit) begin
                        r_state     <= S_DRAIN;
                        r_in_ready  <= 1'b0;
                        r_timed_out <= 1'b1;
                    end else begin
                        r_stall <= r_stall + STALL_W'(1);
                    end
`else
                    else begin
                        r_state <= S_RUN;
                    end
`endif
                end
                S_DRAIN: begin
                    // The last product landed in the MAC at the end of the previous cycle.
                    r_res_data  <= mac_acc;
                    r_res_valid <= 1'b1;
                    r_state     <= S_DONE;
`ifdef MACSEQ_TIMEOUT_EN
                    r_res_err   <= r_timed_out;
`endif
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_state     <= S_IDLE;
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
`ifdef MACSEQ_TIMEOUT_EN
                        r_res_err   <= 1'b0;
`endif
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b0;
                    r_res_valid <= 1'b0;
                    r_mac_clr   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl with a behavioural MAC and sum-of-products reference.
// Define MACSEQ_TIMEOUT_EN to also exercise the stall timeout (TIMEOUT=8).
module tb_mac_seq_ctrl;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;
    localparam int LEN_W  = 8;
`ifdef MACSEQ_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 64;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  len = '0;
    logic              busy;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_x = '0;
    logic [DATA_W-1:0] in_y = '0;
    logic              res_valid;
    logic              res_ready = 1'b1;
    logic [ACC_W-1:0]  res_data;
    logic              res_err;
    logic              mac_rst;
    logic [DATA_W-1:0] mac_x;
    logic [DATA_W-1:0] mac_y;
    logic [ACC_W-1:0]  mac_acc = '0;

    mac_seq_ctrl #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
        .mac_rst(mac_rst), .mac_x(mac_x), .mac_y(mac_y), .mac_acc(mac_acc)
    );

    always #5 clk = ~clk;

    // Behavioural MAC that the sequencer drives.
    always @(posedge clk) begin
        if (mac_rst) mac_acc <= '0;
        else         mac_acc <= mac_acc + ACC_W'(mac_x) * ACC_W'(mac_y);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [ACC_W-1:0] d; logic e; } exp_t;
    exp_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int s_cyc;
    bit ready_seen;
    logic [ACC_W-1:0] last_sum;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every result handshake is popped from the scoreboard.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got %0h expected none", res_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("res_data", res_data, e.d);
                check("res_err", 32'(res_err), 32'(e.e));
            end
        end
    end

    always @(negedge clk) if (in_ready) ready_seen = 1'b1;

    // Issue a job and stream its operands; the expected result is the plain sum of products.
    task automatic drive_job(input int n, input int bub, input int mode,
                             input int abort_after, input int gap);
        logic [ACC_W-1:0] sum;
        int sent, cycles, idle_run, gap_left;
        bit v;
        start = 1'b1;
        len   = LEN_W'(n);
        s_cyc = cyc;
        step();
        start = 1'b0;
        sum = '0; sent = 0; cycles = 0; idle_run = 0; gap_left = 0;
        while (sent < n && sent < abort_after && cycles < 2000) begin
            if (gap_left > 0) begin
                v = 1'b0;
                gap_left--;
            end else begin
                v = ($urandom_range(0, 99) >= bub) || (idle_run >= 3);
            end
            in_valid = v;
            in_x = (mode != 0) ? 16'd5 : 16'($urandom);
            in_y = (mode == 1) ? 16'(sent + 1) : (mode == 2) ? 16'd1 : 16'($urandom);
            if (v && in_ready) begin
                sum = sum + in_x * in_y;
                sent++;
                idle_run = 0;
                gap_left = gap;
            end else begin
                idle_run++;
            end
            step();
            cycles++;
        end
        in_valid = 1'b0;
        in_x = '0;
        in_y = '0;
        if (cycles >= 2000) check("beat_timeout", 32'(sent), 32'(n));
        last_sum = sum;
        if (sent == n) exp_q.push_back('{d: sum, e: 1'b0});
    endtask

    task automatic wait_idle(input bit rand_rr);
        int k = 0;
        while (busy && k < 1000) begin
            if (rand_rr) res_ready = 1'($urandom_range(0, 1));
            step();
            k++;
        end
        res_ready = 1'b1;
        if (k >= 1000) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        step();
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_err", 32'(res_err), 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_mac_rst", 32'(mac_rst), 32'd1);
        check("rst_mac_x", 32'(mac_x), 32'd0);
        rst = 1'b0;
        step();
        check("mac_rst_released", 32'(mac_rst), 32'd0);

        // len=3 back-to-back (5,1),(5,2),(5,3) -> 30, result 2 cycles after last beat.
        drive_job(3, 0, 1, 1000, 0);
        check("drain_no_valid", 32'(res_valid), 32'd0);
        check("drain_busy", 32'(busy), 32'd1);
        step();
        check("done_valid", 32'(res_valid), 32'd1);
        check("start_to_valid", 32'(cyc - s_cyc), 32'd6);
        wait_idle(1'b0);

        // len=0: CLEAR then DONE, never ready.
        ready_seen = 1'b0;
        drive_job(0, 0, 1, 1000, 0);
        check("len0_clear_busy", 32'(busy), 32'd1);
        step();
        check("len0_done_valid", 32'(res_valid), 32'd1);
        check("len0_data", res_data, 32'd0);
        wait_idle(1'b0);
        check("len0_no_ready", 32'(ready_seen), 32'd0);

        // Two-cycle bubbles between beats.
        drive_job(3, 0, 1, 1000, 2);
        wait_idle(1'b0);

        // Back-pressure in DONE: result held, start ignored, start on handshake ignored.
        res_ready = 1'b0;
        drive_job(3, 0, 1, 1000, 0);
        step();
        for (int i = 0; i < 5; i++) begin
            start = ~start;
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_data", res_data, last_sum);
            check("hold_busy", 32'(busy), 32'd1);
            step();
        end
        start = 1'b1;
        res_ready = 1'b1;
        step();
        start = 1'b0;
        check("released_busy", 32'(busy), 32'd0);
        check("released_valid", 32'(res_valid), 32'd0);
        step();
        check("no_queued_start", 32'(busy), 32'd0);

        // Reset after two beats of a len=3 job, then a clean len=2 job of (5,1),(5,1).
        drive_job(3, 0, 1, 2, 0);
        rst = 1'b1;
        #1;
        check("midrst_mac_rst", 32'(mac_rst), 32'd1);
        step();
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_res_valid", 32'(res_valid), 32'd0);
        check("midrst_res_data", res_data, 32'd0);
        check("midrst_mac_x", 32'(mac_x), 32'd0);
        rst = 1'b0;
        step();
        check("midrst_acc_clear", mac_acc, 32'd0);
        drive_job(2, 0, 2, 1000, 0);
        wait_idle(1'b0);

`ifdef MACSEQ_TIMEOUT_EN
        // One beat (5,1) of len=4 then silence: abort after 8 stall cycles with partial 5.
        drive_job(4, 0, 1, 1, 0);
        exp_q.push_back('{d: 32'd5, e: 1'b1});
        for (int i = 0; i < 8; i++) step();
        check("tmo_not_yet", 32'(res_valid), 32'd0);
        step();
        check("tmo_valid", 32'(res_valid), 32'd1);
        wait_idle(1'b0);
        check("tmo_err_cleared", 32'(res_err), 32'd0);
`endif

        // Randomized jobs with bubbles and random result back-pressure.
        for (int j = 0; j < 25; j++) begin
            drive_job(int'($urandom_range(0, 12)), int'($urandom_range(0, 50)), 0, 1000, 0);
            wait_idle(1'b1);
        end
        drive_job(255, 20, 0, 1000, 0);
        wait_idle(1'b1);

        step();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
